exu_brch_pipe: RTL and testbench

Execute-stage output register placed directly downstream of the EXU ALU. It takes each ALU result (`result`, `sububit`) together with the instruction's control payload. It resolves conditional branches and jumps, and for taken control flow issues a one-cycle redirect to the IFU. It then hands the committed beat to the LSU stage through a valid/ready handshake, using a 2-entry skid buffer so the upstream ready signal never depends combinationally on downstream ready.

---
 rtl/exu_brch_pipe.sv | 160 ++++++++++++++++
 tb/tb_exu_brch_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_brch_pipe.sv
// exu_brch_pipe
// Execute-stage output register sitting right after the EXU ALU. It resolves
// conditional branches and jumps, raises a one-cycle redirect toward the IFU
// for taken control flow, and passes every beat to the LSU stage through a
// two-entry (main + skid) valid/ready buffer. Because of the skid entry,
// o_pre_ready is built only from registered state and never depends
// combinationally on i_post_ready.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_flush                 trap/CSR flush, drops all buffered state
//   i_pre_valid/o_pre_ready upstream handshake
//   i_alu_result, i_sububit ALU result and unsigned-subtract borrow
//   i_src1_msb, i_src2_msb  operand sign bits for the signed compare
//   i_brch_op               0 NONE,1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU,7 JUMP
//   i_pc, i_brch_tgt        instruction PC and precomputed branch target
//   i_pay / o_pay           opaque payload, passed through untouched
//   o_post_valid/i_post_ready downstream handshake toward the LSU
//   o_result                writeback value of the beat at the head
//   o_redirect_valid/_pc    one-cycle redirect pulse and its target
module exu_brch_pipe #(
  parameter int CPU_WIDTH = 64,
  parameter int PAY_W     = 48
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [CPU_WIDTH-1:0] i_alu_result,
  input  logic                 i_sububit,
  input  logic                 i_src1_msb,
  input  logic                 i_src2_msb,
  input  logic [2:0]           i_brch_op,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [CPU_WIDTH-1:0] i_brch_tgt,
  input  logic [PAY_W-1:0]     i_pay,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [CPU_WIDTH-1:0] o_result,
  output logic [PAY_W-1:0]     o_pay,
  output logic                 o_redirect_valid,
  output logic [CPU_WIDTH-1:0] o_redirect_pc
);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JUMP = 3'd7
  } brch_op_e;

  brch_op_e op;
  assign op = brch_op_e'(i_brch_op);

  logic                 main_valid;
  logic [CPU_WIDTH-1:0] main_result;
  logic [PAY_W-1:0]     main_pay;
  logic                 skid_valid;
  logic [CPU_WIDTH-1:0] skid_result;
  logic [PAY_W-1:0]     skid_pay;
  logic                 redir_valid;
  logic [CPU_WIDTH-1:0] redir_pc;

  logic                 eq;
  logic                 ltu;
  logic                 lt;
  logic                 taken;
  logic [CPU_WIDTH-1:0] new_result;
  logic                 accept;
  logic                 drain;

  // Ready comes only from registers: a full skid entry or a pending
  // redirect (wrong-path beats must not slip in behind a taken branch).
  assign o_pre_ready = !skid_valid && !redir_valid;
  assign accept      = i_pre_valid && o_pre_ready && !i_flush;
  assign drain       = main_valid && i_post_ready;

  // Branch resolution. When the operand signs differ the signed order is
  // fixed by src1's sign alone; otherwise the unsigned borrow decides.
  always_comb begin
    eq         = (i_alu_result == '0);
    ltu        = i_sububit;
    lt         = (i_src1_msb ^ i_src2_msb) ? i_src1_msb : i_sububit;
    taken      = 1'b0;
    new_result = i_alu_result;
    case (op)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLT:  taken = lt;
      BR_BGE:  taken = !lt;
      BR_BLTU: taken = ltu;
      BR_BGEU: taken = !ltu;
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (op == BR_JUMP) begin
      new_result = i_pc + CPU_WIDTH'(4);
    end else if (op != BR_NONE) begin
      new_result = '0;
    end
  end

  // Main/skid buffer and redirect register. Reset and flush both drop
  // every entry; reset additionally zeroes the data so outputs start at 0.
  // The skid entry can only be occupied while accept is blocked, so a
  // drain with a full skid never coincides with a new accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      redir_valid <= 1'b0;
      if (!i_rst_n) begin
        main_result <= '0;
        main_pay    <= '0;
        skid_result <= '0;
        skid_pay    <= '0;
        redir_pc    <= '0;
      end
    end else begin
      redir_valid <= accept && taken;
      if (accept && taken) begin
        redir_pc <= {i_brch_tgt[CPU_WIDTH-1:1], 1'b0};
      end
      if (drain) begin
        if (skid_valid) begin
          main_result <= skid_result;
          main_pay    <= skid_pay;
          skid_valid  <= 1'b0;
        end else if (accept) begin
          main_result <= new_result;
          main_pay    <= i_pay;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (!main_valid) begin
        if (accept) begin
          main_valid  <= 1'b1;
          main_result <= new_result;
          main_pay    <= i_pay;
        end
      end else if (accept) begin
        skid_valid  <= 1'b1;
        skid_result <= new_result;
        skid_pay    <= i_pay;
      end
    end
  end

  assign o_post_valid     = main_valid;
  assign o_result         = main_result;
  assign o_pay            = main_pay;
  assign o_redirect_valid = redir_valid;
  assign o_redirect_pc    = redir_pc;

endmodule

// File: tb/tb_exu_brch_pipe.sv
// tb_exu_brch_pipe
// Self-checking bench for exu_brch_pipe. A reference model tracks the
// buffered beats as a plain queue (capacity two) plus a pending-redirect
// flag, and decides branches from the real operand values using ordinary
// signed/unsigned comparisons. Directed scenarios are followed by a
// randomized run with back-pressure, flushes and occasional resets.
module tb_exu_brch_pipe;

  localparam int CW = 64;
  localparam int PW = 48;

  logic          clk;
  logic          rstN;
  logic          flush;
  logic          preValid;
  logic          preReady;
  logic [CW-1:0] sAlu;
  logic          sSub;
  logic [CW-1:0] sSrc1;
  logic [CW-1:0] sSrc2;
  logic [2:0]    sOp;
  logic [CW-1:0] sPc;
  logic [CW-1:0] sTgt;
  logic [PW-1:0] sPay;
  logic          postValid;
  logic          postReady;
  logic [CW-1:0] outResult;
  logic [PW-1:0] outPay;
  logic          redirValid;
  logic [CW-1:0] redirPc;

  exu_brch_pipe #(.CPU_WIDTH(CW), .PAY_W(PW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .i_flush          (flush),
    .i_pre_valid      (preValid),
    .o_pre_ready      (preReady),
    .i_alu_result     (sAlu),
    .i_sububit        (sSub),
    .i_src1_msb       (sSrc1[CW-1]),
    .i_src2_msb       (sSrc2[CW-1]),
    .i_brch_op        (sOp),
    .i_pc             (sPc),
    .i_brch_tgt       (sTgt),
    .i_pay            (sPay),
    .o_post_valid     (postValid),
    .i_post_ready     (postReady),
    .o_result         (outResult),
    .o_pay            (outPay),
    .o_redirect_valid (redirValid),
    .o_redirect_pc    (redirPc)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] result;
    logic [PW-1:0] pay;
  } beat_t;

  beat_t         mq[$];
  bit            mRedir = 1'b0;
  logic [CW-1:0] mRedirPc = '0;
  int            numCompared = 0;
  int            numMismatched = 0;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [CW-1:0] obs,
                             input logic [CW-1:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Branch outcome straight from the operand values.
  function automatic bit modelTaken(input logic [2:0] op, input logic [CW-1:0] a,
                                    input logic [CW-1:0] b);
    case (op)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return $signed(a) <  $signed(b);
      3'd4:    return $signed(a) >= $signed(b);
      3'd5:    return a <  b;
      3'd6:    return a >= b;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] modelResult(input logic [2:0] op,
                                                input logic [CW-1:0] alu,
                                                input logic [CW-1:0] pc);
    if (op == 3'd7) return pc + 64'd4;
    if (op != 3'd0) return '0;
    return alu;
  endfunction

  // Present one instruction, producing the ALU outputs a subtracting ALU
  // would give for compare ops.
  task automatic setBeat(input logic [2:0] op, input logic [CW-1:0] a,
                         input logic [CW-1:0] b, input logic [CW-1:0] alu,
                         input logic [CW-1:0] pc, input logic [CW-1:0] tgt,
                         input logic [PW-1:0] pay);
    sOp   = op;
    sSrc1 = a;
    sSrc2 = b;
    sAlu  = (op >= 3'd1 && op <= 3'd6) ? a - b : alu;
    sSub  = (a < b);
    sPc   = pc;
    sTgt  = tgt;
    sPay  = pay;
  endtask

  task automatic checkModel();
    checkOutput("post_valid", {63'd0, postValid}, {63'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      checkOutput("result", outResult, mq[0].result);
      checkOutput("pay", {16'd0, outPay}, {16'd0, mq[0].pay});
    end
    checkOutput("redirect_valid", {63'd0, redirValid}, {63'd0, mRedir});
    if (mRedir) checkOutput("redirect_pc", redirPc, mRedirPc);
    checkOutput("pre_ready", {63'd0, preReady},
                {63'd0, (mq.size() < 2) && !mRedir});
  endtask

  // Drive one cycle of control inputs (called at a falling edge), advance
  // the model across the rising edge, then check at the next falling edge.
  task automatic applyStimulus(input bit valid, input bit ready, input bit fl,
                               input bit rn);
    bit            expReady;
    bit            acc;
    bit            drn;
    bit            tk;
    beat_t         nb;
    logic [CW-1:0] tpc;
    preValid  = valid;
    postReady = ready;
    flush     = fl;
    rstN      = rn;
    expReady  = (mq.size() < 2) && !mRedir;
    acc       = rn && !fl && valid && expReady;
    drn       = (mq.size() > 0) && ready;
    tk        = modelTaken(sOp, sSrc1, sSrc2);
    nb.result = modelResult(sOp, sAlu, sPc);
    nb.pay    = sPay;
    tpc       = sTgt & ~64'd1;
    @(posedge clk);
    if (!rn || fl) begin
      mq.delete();
      mRedir = 1'b0;
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(nb);
      mRedir = acc && tk;
      if (acc && tk) mRedirPc = tpc;
    end
    @(negedge clk);
    checkModel();
  endtask

  task automatic idle(input int n);
    setBeat(3'd0, '0, '0, '0, '0, '0, '0);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    setBeat(3'd0, '0, '0, '0, '0, '0, '0);
    // Reset: outputs are fully zeroed, ready is high.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_result", outResult, '0);
    checkOutput("reset_pay", {16'd0, outPay}, '0);
    checkOutput("reset_redirect_pc", redirPc, '0);
    checkOutput("reset_pre_ready", {63'd0, preReady}, 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Streaming: one beat per cycle, each visible the cycle after accept.
    for (int i = 1; i <= 8; i++) begin
      setBeat(3'd0, '0, '0, 64'(i), '0, '0, 48'(i * 3));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("stream_result", outResult, 64'(i));
      checkOutput("stream_ready", {63'd0, preReady}, 64'd1);
    end
    idle(2);

    // Skid: A and B buffered, C held until B moves into main.
    setBeat(3'd0, '0, '0, 64'h11, '0, '0, 48'hA);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    setBeat(3'd0, '0, '0, 64'h22, '0, '0, 48'hB);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("skid_full_ready", {63'd0, preReady}, 64'd0);
    setBeat(3'd0, '0, '0, 64'h33, '0, '0, 48'hC);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("skid_hold_A", outResult, 64'h11);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("skid_B_main", outResult, 64'h22);
    checkOutput("skid_ready_back", {63'd0, preReady}, 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("skid_C_out", outResult, 64'h33);
    idle(2);

    // Signed vs unsigned compare of -1 against 1.
    setBeat(3'd3, '1, 64'd1, '0, 64'h1000, 64'h2000, 48'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("blt_redirect", {63'd0, redirValid}, 64'd1);
    checkOutput("blt_pc", redirPc, 64'h2000);
    idle(1);
    setBeat(3'd5, '1, 64'd1, '0, 64'h1000, 64'h3000, 48'h2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("bltu_redirect", {63'd0, redirValid}, 64'd0);
    idle(1);

    // JUMP: link value, aligned target, wrong-path beat refused.
    setBeat(3'd7, '0, '0, '0, 64'h8000_0000, 64'h8000_0101, 48'h7);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("jump_result", outResult, 64'h8000_0004);
    checkOutput("jump_pc", redirPc, 64'h8000_0100);
    checkOutput("jump_ready", {63'd0, preReady}, 64'd0);
    setBeat(3'd0, '0, '0, 64'h55, '0, '0, 48'h55);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("jump_pulse_end", {63'd0, redirValid}, 64'd0);
    checkOutput("jump_blocked", {63'd0, postValid}, 64'd0);
    idle(1);

    // Wrap of the link value.
    setBeat(3'd7, '0, '0, '0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 48'h9);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("wrap_result", outResult, '0);
    idle(2);

    // Flush with both entries full and a taken BEQ presented.
    setBeat(3'd0, '0, '0, 64'hA1, '0, '0, 48'hA1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    setBeat(3'd0, '0, '0, 64'hB2, '0, '0, 48'hB2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    setBeat(3'd1, 64'd5, 64'd5, '0, 64'h100, 64'h200, 48'hC3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_post_valid", {63'd0, postValid}, 64'd0);
    checkOutput("flush_redirect", {63'd0, redirValid}, 64'd0);
    checkOutput("flush_ready", {63'd0, preReady}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("flush_no_stale", {63'd0, postValid}, 64'd0);
    end

    // Randomized traffic with back-pressure, flushes and resets.
    for (int i = 0; i < 600; i++) begin
      logic [CW-1:0] a;
      logic [CW-1:0] b;
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b[CW-1] = ~a[CW-1];
      setBeat(3'($urandom_range(0, 7)), a, b, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom},
              {16'($urandom), $urandom});
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             numCompared, numMismatched);
    $finish;
  end

endmodule
